// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execute unit
//
// Purpose: accepts one M-extension operation over valid/ready, computes it one
// bit per cycle (shift-add multiply, restoring divide), holds the result until
// acknowledged, and can be killed by a pipeline flush.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   valid_i  operation request          ready_o  unit can accept (IDLE)
//   op_i     funct3 (MUL..REMU)         rs1_i/rs2_i  operands
//   rd_i     destination tag            flush_i  kill in-flight operation
//   valid_o  result available           ack_i    result consumed
//   res_o    result                     rd_o     tag of result
//   busy_o   CALC or FIX in progress
//
// Optional feature: define MULDIV_FAST_MUL_EN to resolve all multiplies with a
// single-cycle multiplier (IDLE->DONE); the default build iterates them.

module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] rd_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [XLEN-1:0]  res_o,
    output logic [TAG_W-1:0] rd_o,
    output logic             busy_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  rd_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div), absolute
    logic [2*XLEN-1:0] acc;        // {high/remainder, low/multiplier/quotient}
    logic              neg_q;      // product or quotient sign
    logic              rem_neg_q;  // remainder sign (follows dividend)
    logic [XLEN-1:0]   res_q;

    // ---------------- operand preparation at accept ----------------
    logic            rs1_signed, rs2_signed, neg1, neg2;
    logic [XLEN-1:0] abs1, abs2;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        rs1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                     (op_i == OP_DIV)  || (op_i == OP_REM);
        rs2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        neg1       = rs1_signed && rs1_i[XLEN-1];
        neg2       = rs2_signed && rs2_i[XLEN-1];
        abs1       = neg1 ? -rs1_i : rs1_i;
        abs2       = neg2 ? -rs2_i : rs2_i;
        is_div     = op_i[2];
        div_zero   = is_div && (rs2_i == '0);
        div_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                     (rs1_i == MOST_NEG) && (rs2_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? rs1_i : '1;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : MOST_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_mag  = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
        fast_prod = (neg1 ^ neg2) ? -fast_mag : fast_mag;
        fast_res  = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract; the borrow bit decides whether to restore.
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[XLEN];
        if (op_q[2]) begin
            acc_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up and result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                         fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_res = quo;
            default:                        fix_res = rem;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            opnd_q    <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            res_q     <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_q      <= op_i;
                        rd_q      <= rd_i;
                        cnt       <= '0;
                        neg_q     <= neg1 ^ neg2;
                        rem_neg_q <= neg1;
                        opnd_q    <= is_div ? abs2 : abs1;
                        acc       <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
                        if (div_zero || div_ovf) begin
                            res_q <= special_res;
                            state <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            res_q <= fast_res;
                            state <= DONE;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res_q <= fix_res;
                    state <= DONE;
                end
                DONE: begin
                    if (ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign busy_o  = (state == CALC) || (state == FIX);
    assign res_o   = res_q;
    assign rd_o    = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit

module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 0;
`else
    localparam int MLAT = LAT;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i, ready_o, flush_i, valid_o, ack_i, busy_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i, rs2_i, res_o;
    logic [4:0]      rd_i, rd_o;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .rd_i    (rd_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ack_i   (ack_i),
        .res_o   (res_o),
        .rd_o    (rd_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat, input int hold);
        int n;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        check({tag, ".busy"}, 64'(busy_o), 64'(lat != 0));
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(lat));
        check({tag, ".res"}, 64'(res_o), 64'(exp));
        check({tag, ".rd"}, 64'(rd_o), 64'(rd));
        check({tag, ".rdy_lo"}, 64'(ready_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_v"}, 64'(valid_o), 64'd1);
            check({tag, ".hold_res"}, 64'(res_o), 64'(exp));
            check({tag, ".hold_rd"}, 64'(rd_o), 64'(rd));
            check({tag, ".hold_rdy"}, 64'(ready_o), 64'd0);
        end
        ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack_i = 1'b0;
        check({tag, ".rdy_after_ack"}, 64'(ready_o), 64'd1);
        check({tag, ".v_after_ack"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        repeat (2) @(negedge clk);
        check("rst.valid", 64'(valid_o), 64'd0);
        check("rst.busy", 64'(busy_o), 64'd0);
        check("rst.res", 64'(res_o), 64'd0);
        check("rst.rd", 64'(rd_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst.ready", 64'(ready_o), 64'd1);

        // multiplies
        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, MLAT, 0);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, MLAT, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, MLAT, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd5,  32'hFFFFFFFF, MLAT, 0);
        // divides
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, LAT, 0);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, LAT, 0);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd8,  32'd14,       LAT, 0);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        LAT, 0);
        run_op("div_nd", 3'd4, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, LAT, 0);
        run_op("rem_nd", 3'd6, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        LAT, 0);
        // special cases
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0, 0);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        0, 0);
        run_op("remu_z",  3'd7, 32'd5,        32'd0,        5'd15, 32'd5,        0, 0);
        run_op("divu_z",  3'd5, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 0, 0);
        run_op("div_z",   3'd4, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFF, 0, 0);
        // back-pressure: hold in DONE
        run_op("bp", 3'd5, 32'd1000, 32'd10, 5'd18, 32'd100, LAT, 3);

        // flush 10 cycles into a DIV
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd4; rs1_i = 32'd77; rs2_i = 32'd5; rd_i = 5'd19;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        check("flush.ready", 64'(ready_o), 64'd1);
        check("flush.busy", 64'(busy_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("flush.no_valid", 64'(seen), 64'd0);

        // flush coincident with a request in IDLE
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_acc.ready", 64'(ready_o), 64'd1);
        check("flush_acc.valid", 64'(valid_o), 64'd0);
        check("flush_acc.busy", 64'(busy_o), 64'd0);

        // async reset mid-CALC
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; rd_i = 5'd21;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst.busy", 64'(busy_o), 64'(MLAT != 0));
        #2 rst = 1'b0;
        #1;
        check("arst.valid", 64'(valid_o), 64'd0);
        check("arst.busy", 64'(busy_o), 64'd0);
        check("arst.res", 64'(res_o), 64'd0);
        check("arst.rd", 64'(rd_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst.ready", 64'(ready_o), 64'd1);

        // unit still works after reset
        run_op("post_rst", 3'd0, 32'd6, 32'd7, 5'd22, 32'd42, MLAT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
